sd_req_arbiter: RTL
===================

# sd_req_arbiter

Shares the single SD-card sector interface of the MiST IO-controller link (`sd_lba`/`sd_rd`/`sd_wr` out, `sd_ack`/`sd_dout`/`sd_din` strobes back) between up to NREQ core-side disk requesters, e.g. two emulated drives.
- Each grant is held for one full 512-byte sector transfer.
- Data strobes are routed to the granted requester only.
- The block sits between the drive emulations and `user_io`, in the core clock domain. All `sd_*` inputs arrive already synchronized to `clk`, and strobes are single-cycle pulses.

## Interface
- `NREQ`, 2: number of requesters (2..4).
- `TIMEOUT`, 24'd16000000: cycles to wait for `sd_ack` rise before aborting a request.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `req_rd` in NREQ: per-requester sector read request (level, held until `req_done`).
- `req_wr` in NREQ: per-requester sector write request.
- `req_lba` in 32*NREQ: per-requester LBA, slice i = [32*i+31:32*i].
- `req_din` in 8*NREQ: per-requester write data byte.
- `req_ack` out NREQ: one-hot, high while requester i owns the link.
- `req_dout` out 8: read data byte, shared by all requesters.
- `req_dout_strobe` out NREQ: read byte valid for requester i.
- `req_din_strobe` out NREQ: requester i must present the next write byte.
- `req_done` out NREQ: 1-cycle pulse at end of transfer.
- `req_err` out NREQ: 1-cycle pulse, coincident with `req_done`, on timeout or short transfer.
- `sd_lba` out 32: to `user_io`.
- `sd_rd` out 1: to `user_io`.
- `sd_wr` out 1: to `user_io`.
- `sd_ack` in 1: from `user_io`.
- `sd_dout` in 8: from `user_io`.
- `sd_dout_strobe` in 1: from `user_io`.
- `sd_din` out 8: to `user_io`.
- `sd_din_strobe` in 1: from `user_io`.
- `busy` out 1: state != IDLE.

## Operation
States:
- **IDLE**
  - Scan requesters whose `req_rd|req_wr` is set, round-robin, starting at `rr_ptr`.
  - Latch the winner index `gnt`, its LBA and its direction. Write wins if both `rd` and `wr` are set.
  - Set `rr_ptr` = `gnt`+1 (mod NREQ).
  - Go to ISSUE.
- **ISSUE**
  - Drive `sd_lba`=latched LBA; `sd_rd`/`sd_wr` = latched direction.
  - Run the timeout counter.
  - On `sd_ack`=1: clear the byte counter, go to XFER.
  - On counter = TIMEOUT-1: go to DONE with `err`=1.
- **XFER**
  - Keep `sd_rd`/`sd_wr` asserted until the first `sd_ack`=1 cycle, then deassert both.
  - Each `sd_dout_strobe` or `sd_din_strobe` increments the 10-bit byte count, saturating at 512.
  - Forward the strobe to `req_*_strobe[gnt]`.
  - On `sd_ack` falling: go to DONE; `err`=1 if count != 512.
- **DONE**
  - For one cycle: pulse `req_done[gnt]`, and `req_err[gnt]` if `err`.
  - Clear `err`, return to IDLE.
  - Requester must drop its request in the cycle after `req_done`; a request still high in IDLE is treated as a new request.

Routing:
- `req_ack[gnt]`=1 in ISSUE and XFER, otherwise all zero.
- `req_dout` = `sd_dout`, unregistered pass-through.
- `sd_din` = `req_din[gnt]` slice, combinational mux. It is held stable in all states; in IDLE it uses the last `gnt`.
- Strobes that arrive in IDLE/ISSUE/DONE are dropped and not counted.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `gnt`=0, counters 0.
  - `sd_rd`=`sd_wr`=0, `sd_lba`=0.
  - All `req_ack`/`req_done`/`req_err`/`req_*_strobe`=0, `busy`=0.
- Reset mid-transfer:
  - Returns to IDLE within the same edge.
  - No `req_done` pulse; the requester sees `req_ack` drop.
- Request latency: request high at edge N → `sd_rd`/`sd_wr` and `req_ack` high after edge N+1 (registered outputs).
- Strobe forwarding: combinational, zero latency, gated by registered state==XFER and `gnt`.
- Completion: `sd_ack` low sampled at edge M → DONE after M → `req_done` pulse in cycle M+1.
- Back-to-back: next IDLE grant one cycle after DONE, so minimum 3 idle cycles between `sd_rd` assertions.
- Timeout counter: 24 bits, cleared on entry to ISSUE.
- `sd_ack` already high on ISSUE entry (stale) is accepted as the acknowledge.

## Structure
- Package `sd_arb_pkg`:
  - state enum {IDLE, ISSUE, XFER, DONE}
  - `SECTOR_BYTES`=512
  - `CNT_W`=10
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: valid, index.
- All else in one file.

## Test plan
- Single read, NREQ=2, requester 1, LBA 0x00001234:
  - `sd_lba`=0x1234 and `sd_rd`=1 one cycle later.
  - Ack + 512 `sd_dout_strobe` → 512 `req_dout_strobe[1]` pulses.
  - `req_done[1]` pulse, `req_err`=0.
- Simultaneous `req_rd[0]` and `req_wr[1]` from reset:
  - Requester 0 served first, then 1; after that `rr_ptr`=0.
  - Then both again → 0 then 1.
- Write, requester 0:
  - Each `sd_din_strobe` is forwarded to `req_din_strobe[0]`.
  - `sd_din` equals `req_din` slice 0 throughout; 512 bytes complete with no error.
- Short transfer: `sd_ack` falls after 100 strobes → `req_done[0]` and `req_err[0]` pulse together.
- Timeout: TIMEOUT=16, `sd_ack` never rises → `req_err` and `req_done` 17 cycles after ISSUE entry, `sd_rd` deasserted.
- Reset asserted mid-XFER (byte 200):
  - All outputs at reset values next cycle, no `req_done`.
  - A fresh request is then served normally.

Source files
------------

// File: rtl/sd_req_arbiter_pkg.sv
// sd_arb_pkg: FSM states and sector sizing shared by the SD request arbiter
package sd_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
  localparam int SECTOR_BYTES = 512;
  localparam int CNT_W = 10;
endpackage

// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if: requester-side and user_io-side signals of the SD sector link
interface sd_req_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_rd, req_wr, req_ack, req_dout_strobe, req_din_strobe, req_done, req_err;
  logic [32*NREQ-1:0] req_lba;
  logic [8*NREQ-1:0] req_din;
  logic [7:0] req_dout, sd_dout, sd_din;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, sd_ack, sd_dout_strobe, sd_din_strobe, busy;
  modport slave (
    input req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe,
    output req_ack, req_dout, req_dout_strobe, req_din_strobe, req_done, req_err,
           sd_lba, sd_rd, sd_wr, sd_din, busy
  );
  modport master (
    output req_rd, req_wr, req_lba, req_din, sd_ack, sd_dout, sd_dout_strobe, sd_din_strobe,
    input req_ack, req_dout, req_dout_strobe, req_din_strobe, req_done, req_err,
          sd_lba, sd_rd, sd_wr, sd_din, busy
  );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or after ptr wins
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    valid = |req;
    idx = '0;
    j = '0;
    // scan farthest offset first so the nearest requester overwrites
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares one user_io SD sector link among NREQ drive requesters
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter logic [23:0] TIMEOUT = 24'd16000000
) (
  input logic clk,
  input logic reset,
  sd_req_arbiter_if.slave bus
);
  localparam int W = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SECTOR_BYTES);
  state_t state;
  logic [W-1:0] gnt, rr_ptr, pick_idx;
  logic pick_valid, err, owned, xfer;
  logic [23:0] tcnt;
  logic [CNT_W-1:0] bcnt;
  rr_pick #(.N(NREQ), .W(W)) u_pick (
    .req  (bus.req_rd | bus.req_wr),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );
  assign owned = state == ISSUE || state == XFER;
  assign xfer = state == XFER;
  assign bus.busy = state != IDLE;
  assign bus.req_ack = NREQ'(owned) << gnt;
  assign bus.req_done = NREQ'(state == DONE) << gnt;
  assign bus.req_err = NREQ'(state == DONE && err) << gnt;
  // strobes bypass the registers so the requester sees them in the same cycle
  assign bus.req_dout_strobe = NREQ'(xfer && bus.sd_dout_strobe) << gnt;
  assign bus.req_din_strobe = NREQ'(xfer && bus.sd_din_strobe) << gnt;
  assign bus.req_dout = bus.sd_dout;
  assign bus.sd_din = bus.req_din[8*gnt +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      rr_ptr <= '0;
      err <= 1'b0;
      tcnt <= '0;
      bcnt <= '0;
      bus.sd_lba <= '0;
      bus.sd_rd <= 1'b0;
      bus.sd_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          gnt <= pick_idx;
          rr_ptr <= W'((int'(pick_idx) + 1) % NREQ);
          bus.sd_lba <= bus.req_lba[32*pick_idx +: 32];
          bus.sd_wr <= bus.req_wr[pick_idx];
          bus.sd_rd <= ~bus.req_wr[pick_idx];
          tcnt <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          tcnt <= tcnt + 24'd1;
          if (bus.sd_ack) begin
            bus.sd_rd <= 1'b0;
            bus.sd_wr <= 1'b0;
            bcnt <= '0;
            state <= XFER;
          end else if (tcnt == TIMEOUT - 24'd1) begin
            bus.sd_rd <= 1'b0;
            bus.sd_wr <= 1'b0;
            err <= 1'b1;
            state <= DONE;
          end
        end
        XFER: if (!bus.sd_ack) begin
          err <= bcnt != FULL;
          state <= DONE;
        end else if ((bus.sd_dout_strobe || bus.sd_din_strobe) && bcnt != FULL) begin
          bcnt <= bcnt + 1'b1;
        end
        DONE: begin
          err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
